// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Single-outstanding valid/ready data-bus link between the load/store unit
//   (master) and the data memory or bus fabric (slave).
//   bus_addr_out   word-aligned transaction address
//   bus_wdata_out  lane-replicated store data
//   bus_wmask_out  byte enables, 0000 for reads
//   bus_wr_out     1 = write, 0 = read
//   bus_valid_out  transaction request, held until ready or timeout
//   bus_ready_in   transaction accepted/completed
//   bus_rdata_in   read data, valid with bus_valid_out & bus_ready_in
interface load_store_unit_if;
    logic [31:0] bus_addr_out;
    logic [31:0] bus_wdata_out;
    logic [3:0]  bus_wmask_out;
    logic        bus_wr_out;
    logic        bus_valid_out;
    logic        bus_ready_in;
    logic [31:0] bus_rdata_in;

    modport master (
        output bus_addr_out, bus_wdata_out, bus_wmask_out, bus_wr_out, bus_valid_out,
        input  bus_ready_in, bus_rdata_in
    );

    modport slave (
        input  bus_addr_out, bus_wdata_out, bus_wmask_out, bus_wr_out, bus_valid_out,
        output bus_ready_in, bus_rdata_in
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Execute/memory-stage load/store unit for an RV32I core. Converts decoder
//   memory controls into one valid/ready bus transaction at a time, steers
//   store data onto byte lanes and extracts/extends load data. The pipeline
//   is stalled while a transaction is pending; a hung bus is terminated after
//   TIMEOUT_CYCLES cycles of bus_valid_out without bus_ready_in (0 = never).
// Ports
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   mem_wr_req_in          store request
//   mem_rd_req_in          load request
//   misaligned_load_in     suppresses the load request
//   flush_in               trap / pipeline flush
//   load_size_in           00 byte, 01 half, 1x word
//   load_unsigned_in       zero-extend byte/half loads
//   addr_in, store_data_in effective address and rs2 value
//   bus                    data-bus master port
//   load_data_out          aligned, extended load result
//   load_valid_out         one-cycle pulse with a good, non-flushed load
//   bus_error_out          one-cycle pulse on timeout
//   stall_out              combinational pipeline hold
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      mem_wr_req_in,
    input  logic                      mem_rd_req_in,
    input  logic                      misaligned_load_in,
    input  logic                      flush_in,
    input  logic [1:0]                load_size_in,
    input  logic                      load_unsigned_in,
    input  logic [31:0]               addr_in,
    input  logic [31:0]               store_data_in,
    load_store_unit_if.master         bus,
    output logic [31:0]               load_data_out,
    output logic                      load_valid_out,
    output logic                      bus_error_out,
    output logic                      stall_out
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_p1, wdata_p1, load_data_q, wait_cnt_q;
    logic [3:0]  wmask_p1;
    logic [1:0]  size_p1, off_p1;
    logic        wr_p1, unsigned_p1, err_q, flushed_q;
    logic        req_accept, timeout_fire, valid_c;

    function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [1:0] size);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = 8'(rdata >> {off, 3'b000});
        h = 16'(rdata >> {off[1], 4'b0000});
        case (size)
            2'b00:   return uns ? {24'd0, b} : 32'(b);
            2'b01:   return uns ? {16'd0, h} : 32'(h);
            default: return rdata;
        endcase
    endfunction

    // Store wins when both request types are present; a flushed or
    // misaligned-only request never leaves IDLE.
    assign req_accept = (state_q == IDLE) & ~flush_in &
                        (mem_wr_req_in | (mem_rd_req_in & ~misaligned_load_in));

    always_comb begin
        state_d        = state_q;
        timeout_fire   = 1'b0;
        valid_c        = 1'b0;
        stall_out      = 1'b0;
        load_valid_out = 1'b0;
        bus_error_out  = 1'b0;
        case (state_q)
            IDLE: begin
                stall_out = req_accept;
                if (req_accept) state_d = REQ;
            end
            REQ: begin
                valid_c   = 1'b1;
                stall_out = 1'b1;
                if (bus.bus_ready_in) begin
                    state_d = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt_q == TIMEOUT_CYCLES - 1)) begin
                    state_d      = DONE;
                    timeout_fire = 1'b1;
                end
            end
            DONE: begin
                // The same instruction is still presented here, so new
                // requests are deliberately ignored.
                state_d        = IDLE;
                load_valid_out = ~wr_p1 & ~err_q & ~flushed_q & ~flush_in;
                bus_error_out  = err_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            addr_p1     <= '0;
            wdata_p1    <= '0;
            wmask_p1    <= '0;
            wr_p1       <= 1'b0;
            size_p1     <= '0;
            off_p1      <= '0;
            unsigned_p1 <= 1'b0;
            load_data_q <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            flushed_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            // Request capture: bus fields stay frozen for the whole REQ phase
            if (req_accept) begin
                addr_p1     <= {addr_in[31:2], 2'b00};
                wdata_p1    <= store_lanes(store_data_in, load_size_in);
                wmask_p1    <= mem_wr_req_in ? store_mask(load_size_in, addr_in[1:0]) : 4'b0000;
                wr_p1       <= mem_wr_req_in;
                size_p1     <= load_size_in;
                off_p1      <= addr_in[1:0];
                unsigned_p1 <= load_unsigned_in;
                wait_cnt_q  <= '0;
                err_q       <= 1'b0;
                flushed_q   <= 1'b0;
            end
            // Bus phase: a flush only marks the result, never aborts the bus
            if (state_q == REQ) begin
                if (flush_in) flushed_q <= 1'b1;
                if (bus.bus_ready_in) begin
                    if (!wr_p1) load_data_q <= load_extract(bus.bus_rdata_in, size_p1, off_p1, unsigned_p1);
                end else begin
                    wait_cnt_q <= wait_cnt_q + 32'd1;
                    if (timeout_fire) err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.bus_addr_out  = addr_p1;
    assign bus.bus_wdata_out = wdata_p1;
    assign bus.bus_wmask_out = wmask_p1;
    assign bus.bus_wr_out    = wr_p1;
    assign bus.bus_valid_out = valid_c;
    assign load_data_out     = load_data_q;

endmodule
